axis_tensor_loader: RTL and testbench

Parametrised AXI-Stream ingress buffer for the accelerator. It accepts the DMA stream and fills on-chip weight, bias and image memories according to the top-level accelerator state. It then serves those memories to the convolution datapath during START_ACCEL. It replaces the fixed-size 48-row loader and adds:
- generic depths and widths,
- a working load-complete handshake,
- image row/column addressing,
- an optional TLAST framing check.

---
 rtl/accel_pkg.sv | 32 +++
 rtl/axis_tensor_loader_if.sv | 15 +
 rtl/bram.sv | 39 +++
 rtl/axis_tensor_loader.sv | 192 +++++++++++++++++++
 tb/tb_axis_tensor_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: top-level state encoding, loader FSM
// states, default memory geometry and a small address-width helper.
package accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PARAM_LOAD  = 2'd1,
        ST_IMAGE_LOAD  = 2'd2,
        ST_START_ACCEL = 2'd3
    } accel_state_e;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_ACTIVE = 2'd1,
        LD_DONE   = 2'd2
    } ld_state_e;

    localparam int W_DEPTH_DEF  = 12672;
    localparam int B_DEPTH_DEF  = 129;
    localparam int W_BITS_DEF   = 24;
    localparam int B_BITS_DEF   = 8;
    localparam int IMG_ROWS_DEF = 48;
    localparam int IMG_COLS_DEF = 48;
    localparam int PIX_BITS_DEF = 8;
    localparam int AXIS_DATA_W  = 32;

    // Address width for a memory of 'depth' words, never narrower than 1 bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axis_tensor_loader_if.sv
// AXI-Stream bundle feeding the tensor loader. The DMA side uses the master
// modport, the loader uses the slave modport.
interface axis_tensor_loader_if
    import accel_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bram.sv
// Single-port block RAM with a registered read port. The read register
// holds its value while i_re is low and clears on reset; the array itself
// is never reset.
module bram
    import accel_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read: one cycle from address to data, hold when not enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/axis_tensor_loader.sv
// AXI-Stream ingress buffer: fills weight/bias memories in PARAM_LOAD and the
// per-row image memories in IMAGE_LOAD, then serves them in START_ACCEL.
// Optional TLAST framing check enabled by defining AXIS_LOADER_TLAST_CHECK_EN.
module axis_tensor_loader
    import accel_pkg::*;
#(
    parameter int W_DEPTH  = W_DEPTH_DEF,
    parameter int B_DEPTH  = B_DEPTH_DEF,
    parameter int W_BITS   = W_BITS_DEF,
    parameter int B_BITS   = B_BITS_DEF,
    parameter int IMG_ROWS = IMG_ROWS_DEF,
    parameter int IMG_COLS = IMG_COLS_DEF,
    parameter int PIX_BITS = PIX_BITS_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    axis_tensor_loader_if.slave          s_axis,
    input  logic [1:0]                   i_state,
    output logic                         o_load_done,
    output logic                         o_frame_err,
    input  logic [$clog2(W_DEPTH)-1:0]   rd_addr,
    input  logic [$clog2(IMG_COLS)-1:0]  rd_col,
    output logic [W_BITS-1:0]            w_rd_data,
    output logic [B_BITS-1:0]            b_rd_data,
    output logic [IMG_ROWS*PIX_BITS-1:0] img_rd_data
);
    localparam int AW  = $clog2(W_DEPTH);
    localparam int BAW = addr_w(B_DEPTH);
    localparam int CW  = $clog2(IMG_COLS);
    localparam int RW  = addr_w(IMG_ROWS);

    localparam logic [AW-1:0] LP_W_LAST   = AW'(W_DEPTH - 1);
    localparam logic [AW:0]   LP_B_DEPTH  = (AW + 1)'(B_DEPTH);
    localparam logic [RW-1:0] LP_ROW_LAST = RW'(IMG_ROWS - 1);
    localparam logic [CW-1:0] LP_COL_LAST = CW'(IMG_COLS - 1);

    ld_state_e     r_fsm;
    logic [1:0]    r_frame_state;
    logic [AW-1:0] r_addr;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_tready;
    logic          r_done;

    logic          w_accept;
    logic          w_same;
    logic          w_is_param;
    logic          w_is_img;
    logic          w_final;
    logic          w_wr;
    logic          w_rd_en;
    logic          w_early_end;
    logic [AW-1:0] w_waddr;
    logic [BAW-1:0] w_baddr;
    logic [CW-1:0] w_caddr;

    assign w_accept   = s_axis.tvalid & r_tready;
    assign w_same     = (i_state == r_frame_state);
    assign w_is_param = (r_frame_state == ST_PARAM_LOAD);
    assign w_is_img   = (r_frame_state == ST_IMAGE_LOAD);
    assign w_final    = w_is_param ? (r_addr == LP_W_LAST)
                                   : ((r_row == LP_ROW_LAST) && (r_col == LP_COL_LAST));
    // A beat offered in the same cycle as a state change is not written, so
    // writes can never overlap the START_ACCEL read window.
    assign w_wr       = w_accept & w_same;
    assign w_rd_en    = (i_state == ST_START_ACCEL);

    // Single-port memories: read address in START_ACCEL, load counters otherwise.
    assign w_waddr = w_rd_en ? rd_addr : r_addr;
    assign w_baddr = w_rd_en ? rd_addr[BAW-1:0] : r_addr[BAW-1:0];
    assign w_caddr = w_rd_en ? rd_col : r_col;

`ifdef AXIS_LOADER_TLAST_CHECK_EN
    logic r_err;

    assign w_early_end = s_axis.tlast;

    // Sticky framing error: TLAST early, or missing on the final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_wr && (w_final ? !s_axis.tlast : s_axis.tlast)) begin
            r_err <= 1'b1;
        end
    end

    assign o_frame_err = r_err;
`else
    logic w_unused;

    assign w_early_end = 1'b0;
    assign w_unused    = s_axis.tlast;
    assign o_frame_err = 1'b0;
`endif

    // Loader FSM with beat counters, registered tready and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm         <= LD_IDLE;
            r_frame_state <= ST_IDLE;
            r_addr        <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_tready      <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_fsm != LD_IDLE) && !w_same) begin
                // Accelerator state moved away from the frame: abort.
                r_fsm    <= LD_IDLE;
                r_tready <= 1'b0;
                r_addr   <= '0;
                r_row    <= '0;
                r_col    <= '0;
            end else begin
                case (r_fsm)
                    LD_IDLE: begin
                        if ((i_state == ST_PARAM_LOAD) || (i_state == ST_IMAGE_LOAD)) begin
                            r_fsm         <= LD_ACTIVE;
                            r_frame_state <= i_state;
                            r_tready      <= 1'b1;
                            r_addr        <= '0;
                            r_row         <= '0;
                            r_col         <= '0;
                        end
                    end
                    LD_ACTIVE: begin
                        if (w_accept) begin
                            if (w_final) begin
                                r_fsm    <= LD_DONE;
                                r_tready <= 1'b0;
                                r_done   <= 1'b1;
                            end else if (w_early_end) begin
                                r_fsm    <= LD_DONE;
                                r_tready <= 1'b0;
                            end else if (w_is_param) begin
                                r_addr <= r_addr + 1'b1;
                            end else if (r_col == LP_COL_LAST) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                    LD_DONE: begin
                        r_tready <= 1'b0;
                    end
                    default: begin
                        r_fsm    <= LD_IDLE;
                        r_tready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_axis.tready = r_tready;
    assign o_load_done   = r_done;

    bram #(.ADDR_W(AW), .DATA_W(W_BITS), .DEPTH(W_DEPTH)) u_wmem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr & w_is_param),
        .i_re    (w_rd_en),
        .i_addr  (w_waddr),
        .i_wdata (s_axis.tdata[W_BITS-1:0]),
        .o_rdata (w_rd_data)
    );

    bram #(.ADDR_W(BAW), .DATA_W(B_BITS), .DEPTH(B_DEPTH)) u_bmem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr & w_is_param & ({1'b0, r_addr} < LP_B_DEPTH)),
        .i_re    (w_rd_en),
        .i_addr  (w_baddr),
        .i_wdata (s_axis.tdata[31:32-B_BITS]),
        .o_rdata (b_rd_data)
    );

    for (genvar g = 0; g < IMG_ROWS; g++) begin : g_row
        bram #(.ADDR_W(CW), .DATA_W(PIX_BITS), .DEPTH(IMG_COLS)) u_rmem (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_wr & w_is_img & (r_row == RW'(g))),
            .i_re    (w_rd_en),
            .i_addr  (w_caddr),
            .i_wdata (s_axis.tdata[PIX_BITS-1:0]),
            .o_rdata (img_rd_data[g*PIX_BITS +: PIX_BITS])
        );
    end
endmodule

// File: tb/tb_axis_tensor_loader.sv
// Self-checking bench for axis_tensor_loader: parameter frame, image frame
// with random gaps, abort/restart with random data, and TLAST framing.
module tb_axis_tensor_loader;
    import accel_pkg::*;

    localparam int WD   = 12672;
    localparam int BD   = 129;
    localparam int ROWS = 48;
    localparam int COLS = 48;
    localparam int NPIX = ROWS * COLS;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      i_state;
    logic            o_load_done;
    logic            o_frame_err;
    logic [13:0]     rd_addr;
    logic [5:0]      rd_col;
    logic [23:0]     w_rd_data;
    logic [7:0]      b_rd_data;
    logic [ROWS*8-1:0] img_rd_data;

    int errors = 0;
    int checks = 0;

    logic [23:0] w_model   [WD];
    logic [7:0]  b_model   [BD];
    logic [7:0]  img_model [ROWS][COLS];

    axis_tensor_loader_if s_if ();

    axis_tensor_loader dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis      (s_if),
        .i_state     (i_state),
        .o_load_done (o_load_done),
        .o_frame_err (o_frame_err),
        .rd_addr     (rd_addr),
        .rd_col      (rd_col),
        .w_rd_data   (w_rd_data),
        .b_rd_data   (b_rd_data),
        .img_rd_data (img_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one frame; update the reference model on every handshake.
    task automatic stream(input bit is_img, input int nbeats, input int tlast_at,
                          input bit rand_data, input bit gaps, input int max_cycles,
                          output int accepted, output int done_cnt, output int done_lat);
        logic [31:0] data;
        logic [31:0] kk;
        int cyc = 0;
        accepted = 0;
        done_cnt = 0;
        done_lat = -1;
        while (accepted < nbeats && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            if (o_load_done) done_cnt++;
            kk = accepted;
            if (rand_data) data = $urandom;
            else if (is_img) begin
                data = $urandom;
                data[7:0] = 8'(((accepted / COLS) * 3 + (accepted % COLS)) & 8'hFF);
            end else data = {kk[7:0], kk[23:0]};
            s_if.tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_if.tdata  = data;
            s_if.tlast  = (accepted == tlast_at);
            if (s_if.tvalid && s_if.tready) begin
                if (is_img) img_model[accepted / COLS][accepted % COLS] = data[7:0];
                else begin
                    w_model[accepted] = data[23:0];
                    if (accepted < BD) b_model[accepted] = data[31:24];
                end
                accepted++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_if.tvalid = 1'b0;
            s_if.tlast  = 1'b0;
            if (o_load_done) begin
                if (done_lat < 0) done_lat = i;
                done_cnt++;
            end
        end
    endtask

    task automatic set_state(input logic [1:0] st);
        @(negedge clk);
        i_state = st;
    endtask

    task automatic read_w(input int addr, output logic [23:0] w, output logic [7:0] b);
        @(negedge clk);
        rd_addr = 14'(addr);
        @(negedge clk);
        w = w_rd_data;
        b = b_rd_data;
    endtask

    task automatic read_img(input int c, output logic [ROWS*8-1:0] v, output logic [ROWS*8-1:0] e);
        @(negedge clk);
        rd_col = 6'(c);
        @(negedge clk);
        v = img_rd_data;
        for (int r = 0; r < ROWS; r++) e[r*8 +: 8] = img_model[r][c];
    endtask

    task automatic test_reset();
        rst = 1'b1; i_state = ST_PARAM_LOAD; rd_addr = '0; rd_col = '0;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%0b exp=0", s_if.tready); end
        checks++; if (o_load_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", o_load_done); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", o_frame_err); end
        checks++; if (w_rd_data !== 24'd0) begin errors++; $display("FAIL reset_wdata got=%0h exp=0", w_rd_data); end
        checks++; if (img_rd_data !== '0) begin errors++; $display("FAIL reset_img got=%0h exp=0", img_rd_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL release_tready got=%0b exp=1", s_if.tready); end
    endtask

    task automatic test_param_frame();
        int acc, dn, lat, a;
        logic [23:0] w;
        logic [7:0] b;
        stream(1'b0, WD, WD - 1, 1'b0, 1'b0, WD + 20, acc, dn, lat);
        checks++; if (acc != WD) begin errors++; $display("FAIL param_beats got=%0d exp=%0d", acc, WD); end
        checks++; if (dn != 1) begin errors++; $display("FAIL param_done_count got=%0d exp=1", dn); end
        checks++; if (lat != 0) begin errors++; $display("FAIL param_done_latency got=%0d exp=0", lat); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL param_tready_after got=%0b exp=0", s_if.tready); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL param_err got=%0b exp=0", o_frame_err); end
        set_state(ST_START_ACCEL);
        read_w(5, w, b);
        checks++; if (w !== 24'd5) begin errors++; $display("FAIL param_w5 got=%0d exp=5", w); end
        checks++; if (b !== 8'd5) begin errors++; $display("FAIL param_b5 got=%0d exp=5", b); end
        read_w(BD - 1, w, b);
        checks++; if (b !== 8'(BD - 1)) begin errors++; $display("FAIL param_b_last got=%0d exp=%0d", b, BD - 1); end
        read_w(WD - 1, w, b);
        checks++; if (w !== 24'(WD - 1)) begin errors++; $display("FAIL param_w_last got=%0d exp=%0d", w, WD - 1); end
        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(0, WD - 1);
            read_w(a, w, b);
            checks++; if (w !== w_model[a]) begin errors++; $display("FAIL param_w_rand addr=%0d got=%0h exp=%0h", a, w, w_model[a]); end
        end
        // Read outputs hold outside START_ACCEL.
        @(negedge clk);
        i_state = ST_IDLE;
        rd_addr = 14'd5;
        repeat (2) @(negedge clk);
        checks++; if (w_rd_data !== w_model[a]) begin errors++; $display("FAIL read_hold got=%0h exp=%0h", w_rd_data, w_model[a]); end
    endtask

    task automatic test_image_frame();
        int acc, dn, lat, c;
        logic [ROWS*8-1:0] v, e;
        set_state(ST_IMAGE_LOAD);
        stream(1'b1, NPIX, NPIX - 1, 1'b0, 1'b1, 20000, acc, dn, lat);
        checks++; if (acc != NPIX) begin errors++; $display("FAIL img_beats got=%0d exp=%0d", acc, NPIX); end
        checks++; if (dn != 1) begin errors++; $display("FAIL img_done_count got=%0d exp=1", dn); end
        checks++; if (lat != 0) begin errors++; $display("FAIL img_done_latency got=%0d exp=0", lat); end
        set_state(ST_START_ACCEL);
        read_img(10, v, e);
        checks++; if (v[7*8 +: 8] !== 8'd31) begin errors++; $display("FAIL img_r7c10 got=%0d exp=31", v[7*8 +: 8]); end
        read_img(COLS - 1, v, e);
        checks++; if (v[(ROWS-1)*8 +: 8] !== 8'(((ROWS - 1) * 3 + COLS - 1) & 255)) begin
            errors++; $display("FAIL img_last_pixel got=%0d exp=%0d", v[(ROWS-1)*8 +: 8], ((ROWS - 1) * 3 + COLS - 1) & 255);
        end
        for (int i = 0; i < 4; i++) begin
            c = $urandom_range(0, COLS - 1);
            read_img(c, v, e);
            checks++; if (v !== e) begin errors++; $display("FAIL img_col col=%0d got=%0h exp=%0h", c, v, e); end
        end
    endtask

    task automatic test_abort();
        int acc, dn, lat, a, late_done;
        logic [23:0] w;
        logic [7:0] b;
        set_state(ST_IDLE);
        set_state(ST_PARAM_LOAD);
        stream(1'b0, 100, -1, 1'b1, 1'b0, 200, acc, dn, lat);
        checks++; if (acc != 100) begin errors++; $display("FAIL abort_beats got=%0d exp=100", acc); end
        set_state(ST_IDLE);
        late_done = dn;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_load_done) late_done++;
        end
        checks++; if (late_done != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", late_done); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL abort_tready got=%0b exp=0", s_if.tready); end
        set_state(ST_PARAM_LOAD);
        stream(1'b0, WD, WD - 1, 1'b1, 1'b0, WD + 20, acc, dn, lat);
        checks++; if (acc != WD) begin errors++; $display("FAIL restart_beats got=%0d exp=%0d", acc, WD); end
        checks++; if (dn != 1) begin errors++; $display("FAIL restart_done got=%0d exp=1", dn); end
        set_state(ST_START_ACCEL);
        read_w(0, w, b);
        checks++; if (w !== w_model[0]) begin errors++; $display("FAIL restart_w0 got=%0h exp=%0h", w, w_model[0]); end
        checks++; if (b !== b_model[0]) begin errors++; $display("FAIL restart_b0 got=%0h exp=%0h", b, b_model[0]); end
        for (int i = 0; i < 6; i++) begin
            a = (i < 2) ? 99 + i : $urandom_range(0, BD - 1);
            read_w(a, w, b);
            checks++; if (w !== w_model[a] || b !== b_model[a]) begin
                errors++; $display("FAIL restart_rand addr=%0d got=%0h/%0h exp=%0h/%0h", a, w, b, w_model[a], b_model[a]);
            end
        end
    endtask

    task automatic test_tlast_early();
        int acc, dn, lat, c;
        logic [ROWS*8-1:0] v, e;
        set_state(ST_IMAGE_LOAD);
`ifdef AXIS_LOADER_TLAST_CHECK_EN
        stream(1'b1, NPIX, 50, 1'b1, 1'b0, 80, acc, dn, lat);
        checks++; if (acc != 51) begin errors++; $display("FAIL tlast_beats got=%0d exp=51", acc); end
        checks++; if (dn != 0) begin errors++; $display("FAIL tlast_no_done got=%0d exp=0", dn); end
        checks++; if (o_frame_err !== 1'b1) begin errors++; $display("FAIL tlast_err got=%0b exp=1", o_frame_err); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL tlast_tready got=%0b exp=0", s_if.tready); end
        set_state(ST_IDLE);
        repeat (2) @(negedge clk);
        checks++; if (o_frame_err !== 1'b1) begin errors++; $display("FAIL tlast_err_sticky got=%0b exp=1", o_frame_err); end
`else
        stream(1'b1, NPIX, 50, 1'b1, 1'b0, NPIX + 20, acc, dn, lat);
        checks++; if (acc != NPIX) begin errors++; $display("FAIL tlast_beats got=%0d exp=%0d", acc, NPIX); end
        checks++; if (dn != 1) begin errors++; $display("FAIL tlast_done got=%0d exp=1", dn); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL tlast_err got=%0b exp=0", o_frame_err); end
        set_state(ST_START_ACCEL);
        for (int i = 0; i < 3; i++) begin
            c = $urandom_range(0, COLS - 1);
            read_img(c, v, e);
            checks++; if (v !== e) begin errors++; $display("FAIL tlast_img col=%0d got=%0h exp=%0h", c, v, e); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_param_frame();
        test_image_frame();
        test_abort();
        test_tlast_early();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
